// File: rtl/data_sram_like_bridge_if.sv
// data_sram_like_bridge_if
//   Bundle of the sram-like data bus (req / addr_ok / data_ok).
//   master : the bridge; it drives request, write flag, size, strobes, address and write data.
//   slave  : the memory side; it drives addr_ok, data_ok and read data.
//   Handshake: a request is accepted in the cycle where data_req and data_addr_ok are both
//   high; its response is the next cycle (strictly later) where data_data_ok is high, and
//   responses return in request order. data_data_ok is always consumed, never back-pressured.
interface data_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge
//   Data-side bridge between the MEM stage of the 5-stage MIPS pipe and the sram-like
//   data bus. Turns a single-cycle MEM load/store into a split address/data handshake,
//   raises d_stall while the access is unfinished and holds the result until the MEM
//   register advances, so a frozen MEM stage never re-issues the access.
//
//   Ports
//     clk, rst        : clock, asynchronous active-high reset
//     mem_en/wr/size/sel/addr/wdata : MEM-stage access request
//     mem_cancel      : MEM-stage exception, suppresses issue (looked at only when idle)
//     pipe_adv        : MEM register advances this cycle
//     mem_rdata       : load data to the datapath
//     d_stall         : MEM access not finished
//     bus             : sram-like data bus, master side
//     dbg_state       : current FSM state (IDLE=0, ADDR=1, DATA=2, DONE=3)
//
//   Build option: define DBRIDGE_WBUF_EN for a one-entry posted store. A store then
//   finishes for the pipeline at addr_ok and its data_ok retires it in the background;
//   no new access issues while it is outstanding.
module data_sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_cancel,
  input  logic              pipe_adv,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              d_stall,
  data_sram_like_bridge_if.master bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef DBRIDGE_WBUF_EN
  localparam bit WBUF_EN = 1'b1;
`else
  localparam bit WBUF_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic live;       // MEM holds an access that is allowed to go to the bus
  logic start;      // access issues this cycle
  logic blocked;    // a posted store still owns the bus
  logic posted_hs;  // a posted store is accepted this cycle

`ifdef DBRIDGE_WBUF_EN
  logic wb_pend_q, wb_pend_d;

  // The data_ok that frees the buffer also lets the next access issue in the same cycle.
  assign blocked = wb_pend_q & ~bus.data_data_ok;

  always_comb begin
    wb_pend_d = wb_pend_q;
    if (bus.data_data_ok) wb_pend_d = 1'b0;
    if (posted_hs)        wb_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_pend_q <= 1'b0;
    else     wb_pend_q <= wb_pend_d;
  end
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    posted_hs = 1'b0;

    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd0;
    bus.data_wstrb = 4'd0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;

    d_stall   = 1'b0;
    mem_rdata = rdata_q;

    // rst gating keeps every output at zero while reset is held, even if MEM is active.
    live  = mem_en & ~mem_cancel & ~rst;
    start = live & (state_q == S_IDLE) & ~blocked;

    case (state_q)
      S_IDLE: begin
        if (live & blocked) d_stall = 1'b1;
        if (start) begin
          bus.data_req   = 1'b1;
          bus.data_wr    = mem_wr;
          bus.data_size  = mem_size;
          bus.data_wstrb = mem_sel;
          bus.data_addr  = mem_addr;
          bus.data_wdata = mem_wdata;
          wr_d    = mem_wr;
          size_d  = mem_size;
          sel_d   = mem_sel;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          if (bus.data_addr_ok) begin
            posted_hs = WBUF_EN & mem_wr;
            if (posted_hs) begin
              state_d = pipe_adv ? S_IDLE : S_DONE;
            end else begin
              state_d = S_DATA;
              d_stall = 1'b1;
            end
          end else begin
            state_d = S_ADDR;
            d_stall = 1'b1;
          end
        end
      end
      S_ADDR: begin
        // MEM inputs may change once issued; the bus keeps the latched copy.
        bus.data_req   = 1'b1;
        bus.data_wr    = wr_q;
        bus.data_size  = size_q;
        bus.data_wstrb = sel_q;
        bus.data_addr  = addr_q;
        bus.data_wdata = wdata_q;
        if (bus.data_addr_ok) begin
          posted_hs = WBUF_EN & wr_q;
          if (posted_hs) begin
            state_d = pipe_adv ? S_IDLE : S_DONE;
          end else begin
            state_d = S_DATA;
            d_stall = 1'b1;
          end
        end else begin
          d_stall = 1'b1;
        end
      end
      S_DATA: begin
        if (bus.data_data_ok) begin
          rdata_d   = bus.data_rdata;
          mem_rdata = bus.data_rdata;
          state_d   = pipe_adv ? S_IDLE : S_DONE;
        end else begin
          d_stall = 1'b1;
        end
      end
      S_DONE: begin
        if (pipe_adv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sel_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// tb_data_sram_like_bridge
//   Bench for data_sram_like_bridge. A driver plays both the MEM stage and the bus
//   slave from a transaction-level model (pending-response queue, per-access wait
//   counts) and pushes the expected per-cycle outputs into exp_q; a monitor pops one
//   entry per cycle and compares. Directed cases first, then randomized accesses.
`timescale 1ns/1ps
module tb_data_sram_like_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef DBRIDGE_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_en, mem_wr, mem_cancel, pipe_adv, d_stall;
  logic [1:0] mem_size, dbg_state;
  logic [3:0] mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_sram_like_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_sram_like_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cancel(mem_cancel),
    .pipe_adv(pipe_adv), .mem_rdata(mem_rdata), .d_stall(d_stall),
    .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        req;
    logic        stall;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_chk;
    logic [31:0] rdata;
    logic        ret;
    logic [7:0]  stall_total;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_req"},   32'(bus.data_req), 32'd0);
    check({tag, " d_stall"},    32'(d_stall), 32'd0);
    check({tag, " mem_rdata"},  mem_rdata, 32'd0);
    check({tag, " data_wr"},    32'(bus.data_wr), 32'd0);
    check({tag, " data_size"},  32'(bus.data_size), 32'd0);
    check({tag, " data_wstrb"}, 32'(bus.data_wstrb), 32'd0);
    check({tag, " data_addr"},  bus.data_addr, 32'd0);
    check({tag, " data_wdata"}, bus.data_wdata, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    int dut_stalls;
    dut_stalls = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dut_stalls = 0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_req",   32'(bus.data_req), 32'(e.req));
        check("d_stall",    32'(d_stall), 32'(e.stall));
        check("data_wr",    32'(bus.data_wr), 32'(e.wr));
        check("data_size",  32'(bus.data_size), 32'(e.size));
        check("data_wstrb", 32'(bus.data_wstrb), 32'(e.strb));
        check("data_addr",  bus.data_addr, e.addr);
        check("data_wdata", bus.data_wdata, e.wdata);
        if (e.rd_chk) check("mem_rdata", mem_rdata, e.rdata);
        if (d_stall) dut_stalls++;
        if (e.ret) begin
          check("stall_cycles", dut_stalls, 32'(e.stall_total));
          dut_stalls = 0;
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  // Current MEM instruction
  bit          cur_en, cur_wr, cur_cancel;
  logic [1:0]  cur_size;
  logic [3:0]  cur_sel;
  logic [31:0] cur_addr, cur_wdata;
  int          cur_aw, cur_dw, cur_hold;
  bit          acc, fin, issued, retired;
  int          addr_cnt, blocked_cnt;
  logic [31:0] load_val;
  // Bus slave: accepted requests awaiting data_ok, in order
  bit          pend_posted[$];
  int          pend_wt[$];
  bit          wb_busy;
  bit          use_next;
  logic [31:0] next_rdata;

  // One clock cycle: drive inputs, push expected outputs, then advance the model.
  task automatic step();
    bit live, dok, blocked, ereq, aok, hs, posted, cdok, fin_now, estall, padv, ret;
    logic [31:0] rd_now;
    exp_t e;
    live    = cur_en && !cur_cancel;
    dok     = (pend_wt.size() > 0) && (pend_wt[0] == 0);
    posted  = WBUF && cur_wr;
    cdok    = dok && cur_en && acc && !fin;
    rd_now  = (cdok && use_next) ? next_rdata : $urandom;
    blocked = WBUF && wb_busy && !dok;
    ereq    = live && !acc && !fin && !blocked;
    aok     = ereq ? (addr_cnt >= cur_aw) : 1'($urandom_range(0, 1));
    hs      = ereq && aok;
    fin_now = fin || cdok || (hs && posted);
    estall  = live && !fin_now;
    padv    = (cur_en && !estall) ? (cur_hold == 0) : 1'($urandom_range(0, 1));
    ret     = cur_en && !estall && padv;

    mem_en = cur_en;
    if (cur_en && !issued) begin
      mem_wr = cur_wr; mem_size = cur_size; mem_sel = cur_sel;
      mem_addr = cur_addr; mem_wdata = cur_wdata; mem_cancel = cur_cancel;
    end else begin
      mem_wr = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 3));
      mem_sel = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
      mem_cancel = 1'($urandom_range(0, 1));
    end
    bus.data_addr_ok = aok;
    bus.data_data_ok = dok;
    bus.data_rdata   = rd_now;
    pipe_adv         = padv;

    e = '0;
    e.req   = ereq;
    e.stall = estall;
    if (ereq) begin
      e.wr = cur_wr; e.size = cur_size; e.strb = cur_sel;
      e.addr = cur_addr; e.wdata = cur_wdata;
    end
    e.rd_chk = live && !cur_wr && fin_now;
    e.rdata  = cdok ? rd_now : load_val;
    e.ret    = ret;
    // Spec-level stall cost: cycles blocked behind a posted store, plus addr_ok waits,
    // plus (unless posted) the issue cycle and the data_ok waits.
    e.stall_total = 8'(blocked_cnt + ((live && blocked) ? 1 : 0) +
                       (cur_cancel ? 0 : cur_aw + (posted ? 0 : 1 + cur_dw)));
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (pend_wt.size() > 0 && !dok) pend_wt[0] = pend_wt[0] - 1;
    if (dok) begin
      if (!pend_posted[0] && !cdok) $display("note: unexpected data_ok owner at %0t", $time);
      if (pend_posted[0]) wb_busy = 1'b0;
      void'(pend_posted.pop_front());
      void'(pend_wt.pop_front());
    end
    if (cdok) begin
      load_val = rd_now;
      use_next = 1'b0;
    end
    if (hs) begin
      pend_posted.push_back(posted);
      pend_wt.push_back(cur_dw);
      acc = 1'b1;
      if (posted) wb_busy = 1'b1;
    end
    if (ereq && !aok) addr_cnt++;
    if (live && blocked) blocked_cnt++;
    if (ereq) issued = 1'b1;
    fin = fin_now;
    if (cur_en && !estall && !padv && cur_hold > 0) cur_hold--;
    if (ret) begin
      cur_en  = 1'b0;
      retired = 1'b1;
    end
  endtask

  task automatic load_instr(input bit wr, input logic [1:0] size, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit cancel, input int aw, input int dw, input int hold);
    cur_en = 1'b1; cur_wr = wr; cur_size = size; cur_sel = sel;
    cur_addr = addr; cur_wdata = wdata; cur_cancel = cancel;
    cur_aw = aw; cur_dw = dw; cur_hold = hold;
    acc = 1'b0; fin = 1'b0; issued = 1'b0; retired = 1'b0;
    addr_cnt = 0; blocked_cnt = 0;
  endtask

  task automatic run_instr(input bit wr, input logic [1:0] size, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit cancel, input int aw, input int dw, input int hold);
    load_instr(wr, size, sel, addr, wdata, cancel, aw, dw, hold);
    for (int i = 0; i < 100 && !retired; i++) step();
    check("retire_bound", 32'(retired), 32'd1);
    cur_en = 1'b0;
  endtask

  task automatic idle(input int n);
    cur_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    cur_en = 1'b0; wb_busy = 1'b0; use_next = 1'b0; load_val = '0; next_rdata = '0;
    rst = 1'b1;
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_sel = 4'hf;
    mem_addr = 32'h1000; mem_wdata = 32'h0; mem_cancel = 1'b0; pipe_adv = 1'b1;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Best-case load: one stall cycle, data forwarded in the data_ok cycle.
    use_next = 1'b1; next_rdata = 32'hDEADBEEF;
    run_instr(1'b0, 2'd2, 4'hf, 32'h1000, 32'h0, 1'b0, 0, 0, 0);
    // addr_ok three cycles late, data_ok two cycles after addr_ok: five stall cycles.
    run_instr(1'b0, 2'd2, 4'hf, 32'h1004, 32'h0, 1'b0, 3, 1, 0);
    // Load completing into a frozen MEM stage for four cycles.
    run_instr(1'b0, 2'd1, 4'h3, 32'h1008, 32'h0, 1'b0, 0, 1, 4);
    // Cancelled access never reaches the bus.
    run_instr(1'b0, 2'd2, 4'hf, 32'h100c, 32'h0, 1'b1, 0, 0, 2);
    // Word store, then a load right behind it.
    run_instr(1'b1, 2'd2, 4'hf, 32'h2004, 32'h12345678, 1'b0, 0, WBUF ? 2 : 0, 0);
    run_instr(1'b0, 2'd2, 4'hf, 32'h2004, 32'h0, 1'b0, 0, 0, 0);
    idle(1);

    // Reset while the load sits waiting for data_ok.
    load_instr(1'b0, 2'd2, 4'hf, 32'h3000, 32'h0, 1'b0, 0, 6, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    cur_en = 1'b0; wb_busy = 1'b0; use_next = 1'b0; load_val = '0;
    pend_posted.delete();
    pend_wt.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    use_next = 1'b1; next_rdata = 32'hCAFE0123;
    run_instr(1'b0, 2'd2, 4'hf, 32'h3000, 32'h0, 1'b0, 1, 1, 1);

    // Randomized accesses with random bus latencies, hold cycles and gaps.
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, 2));
      run_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom),
                $urandom, $urandom, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Let a trailing posted store retire, then drain the scoreboard.
    for (int i = 0; i < 20 && pend_wt.size() > 0; i++) idle(1);
    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("bus_drained", 32'(pend_wt.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_like_bridge.md
# data_sram_like_bridge

Data-side memory bridge between the MEM stage of the 5-stage MIPS datapath and the sram-like data bus (req/addr_ok/data_ok). Converts the MEM stage's single-cycle load/store request into a split address/data handshake, generates `d_stall` for the hazard unit, and returns load data as `readdataM` to the datapath's MEM-stage load formatter. Holds a completed result until the pipeline advances, so a frozen MEM stage never re-issues an access.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-high
- `mem_en`  in  1  MEM stage holds a valid load or store
- `mem_wr`  in  1  1 = store, 0 = load
- `mem_size`  in  2  0 byte, 1 half, 2 word
- `mem_sel`  in  4  byte enables for stores
- `mem_addr`  in  ADDR_W  effective address (`aluoutM`)
- `mem_wdata`  in  DATA_W  aligned store data
- `mem_cancel`  in  1  MEM-stage exception; suppresses issue
- `pipe_adv`  in  1  MEM register advances this cycle (`~stallM`)
- `mem_rdata`  out  DATA_W  load data to datapath
- `d_stall`  out  1  MEM access not finished
- `data_req`, `data_wr`  out  1  bus request, write flag
- `data_size`  out  2  bus size
- `data_wstrb`  out  4  bus byte enables
- `data_addr`  out  ADDR_W  bus address
- `data_wdata`  out  DATA_W  bus write data
- `data_addr_ok`, `data_data_ok`  in  1  bus handshakes
- `data_rdata`  in  DATA_W  bus read data

## Operation
- `start` = `mem_en & ~mem_cancel & state==IDLE`.
- States: IDLE, ADDR (req held, awaiting `addr_ok`), DATA (awaiting `data_ok`), DONE (result held).
- IDLE: `data_req`=`start`; bus fields driven from `mem_*` inputs; on `start` latch wr/size/sel/addr/wdata. `start & addr_ok` → DATA; `start & ~addr_ok` → ADDR.
- ADDR: `data_req`=1, bus fields from latched registers; `addr_ok` → DATA.
- DATA: `data_req`=0; on `data_ok`: `rdata_q`←`data_rdata`; `pipe_adv` → IDLE, else → DONE.
- DONE: no request; `mem_rdata`=`rdata_q`; `pipe_adv` → IDLE.
- `d_stall` = `start | ADDR | (DATA & ~data_ok)`; low in DONE and on idle/cancelled cycles.
- `mem_rdata` = `data_rdata` in DATA when `data_ok`, else `rdata_q`.
- `mem_cancel` is sampled only in IDLE; an issued transaction always completes, and `data_ok` is never dropped.
- `d_stall` never depends combinationally on `pipe_adv`.
- Bus fields are zero when `data_req`=0.

## Timing
- Reset: state IDLE; `rdata_q`, `mem_rdata`, `d_stall`, `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata` all 0. Reset mid-transaction abandons it (bus slave shares reset).
- Best case: `addr_ok` in issue cycle, `data_ok` next cycle → `d_stall` high exactly 1 cycle.
- Each extra `addr_ok` or `data_ok` wait cycle adds 1 stall cycle.
- After DONE/DATA→IDLE, a back-to-back access issues in the cycle its inputs appear.

## Configuration
- `DBRIDGE_WBUF_EN` defined: one-entry posted store.
  - A store completes for the pipeline at `addr_ok`: `d_stall` low that cycle; next state IDLE if `pipe_adv`, else DONE.
  - Flag `wb_pend` is set at store `addr_ok` and cleared at `data_ok`.
  - While `wb_pend` and no `data_ok`, `start` is blocked and `d_stall`=`mem_en & ~mem_cancel`.
  - A `data_ok` arriving with `wb_pend` set retires the store and is never taken as load data.
- Undefined: stores wait for `data_ok` exactly like loads; no `wb_pend` logic.

## Test plan
- Load 0x1000, `addr_ok` at cycle 0, `data_ok`+`rdata`=0xDEADBEEF at cycle 1 -> `d_stall` 1,0; `mem_rdata`=0xDEADBEEF at cycle 1; one `data_req` pulse.
- Load with `addr_ok` delayed 3 cycles and `data_ok` delayed 2 more -> `d_stall` high 5 cycles; `data_addr` stable while `data_req` high.
- Load completes with `pipe_adv`=0 for 4 cycles -> state DONE, `d_stall`=0, `mem_rdata` held, zero extra `data_req`.
- `mem_en`=1 with `mem_cancel`=1 -> no `data_req`, `d_stall`=0.
- Store word 0x12345678 to 0x2004 (`sel`=1111): without macro `d_stall` 1,0; with `DBRIDGE_WBUF_EN`, `d_stall`=0 at `addr_ok`; a following load waits for store `data_ok`.
- `rst` pulsed while in DATA -> all outputs 0 immediately; a new load afterwards completes normally.
